// File: rtl/sk_eta_packer.sv
// Centres sampled eta coefficients into polynomial RAM writes and packs the raw coefficients
// LSB-first into the secret-key byte stream through a small first-word-fall-through FIFO.
module sk_eta_packer #(
  parameter int unsigned Q          = 8380417,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_security_level,
  input  logic        i_coeff_valid,
  input  logic [3:0]  i_coeff_data,
  output logic        o_poly_we,
  output logic [7:0]  o_poly_addr,
  output logic [22:0] o_poly_data,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte_data,
  input  logic        i_byte_ready,
  output logic        o_done,
  output logic        o_overflow,
  output logic        o_range_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [22:0] QMod = 23'(Q);
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0]  eta_q, width_q;
  logic [7:0]  cnt_q;
  logic [11:0] acc_q;
  logic [3:0]  fill_q;
  logic        poly_we_q;
  logic [7:0]  poly_addr_q;
  logic [22:0] poly_data_q;
  logic        range_err_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic            overflow_q;

  logic        run, accept, eta4;
  logic [3:0]  coeff_mask, coeff_bits;
  logic [11:0] acc_sum, acc_d;
  logic [3:0]  fill_sum, fill_d;
  logic        emit;
  logic [22:0] eta_ext, coeff_ext, poly_data_d;
  logic        range_hit;
  logic        push, pop, full, wr_en, drop;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; i_start restarts from any state
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = StRun;
    end else begin
      case (state_q)
        StRun:   if (accept && (cnt_q == 8'd255)) state_d = StDrain;
        StDrain: if (fifo_cnt_q == '0) state_d = StDone;
        default: ;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    run    = (state_q == StRun);
    o_done = (state_q == StDone);
  end

  assign eta4   = (i_security_level == 3'd3);
  assign accept = run && i_coeff_valid && !i_start;

  // Bit accumulator: at most 7 leftover bits plus a 4-bit coefficient fits in 12 bits
  always_comb begin
    coeff_mask = (width_q == 3'd4) ? 4'hf : 4'h7;
    coeff_bits = i_coeff_data & coeff_mask;
    acc_sum    = acc_q | ({8'd0, coeff_bits} << fill_q);
    fill_sum   = fill_q + {1'b0, width_q};
    emit       = (fill_sum >= 4'd8);
    acc_d      = emit ? (acc_sum >> 8) : acc_sum;
    fill_d     = emit ? (fill_sum - 4'd8) : fill_sum;
  end

  // Centred value eta - c, wrapped into [0, Q) when negative
  always_comb begin
    eta_ext     = {20'd0, eta_q};
    coeff_ext   = {19'd0, i_coeff_data};
    poly_data_d = (coeff_ext <= eta_ext) ? (eta_ext - coeff_ext)
                                         : (QMod + eta_ext - coeff_ext);
    range_hit   = (i_coeff_data > {eta_q, 1'b0});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eta_q       <= '0;
      width_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      poly_we_q   <= 1'b0;
      poly_addr_q <= '0;
      poly_data_q <= '0;
      range_err_q <= 1'b0;
    end else if (i_start) begin
      eta_q       <= eta4 ? 3'd4 : 3'd2;
      width_q     <= eta4 ? 3'd4 : 3'd3;
      cnt_q       <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      poly_we_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      poly_we_q <= accept;
      if (accept) begin
        cnt_q       <= cnt_q + 8'd1;
        acc_q       <= acc_d;
        fill_q      <= fill_d;
        poly_addr_q <= cnt_q;
        poly_data_q <= poly_data_d;
        if (range_hit) range_err_q <= 1'b1;
      end
    end
  end

  // Output FIFO; a push into a full FIFO is still accepted when a pop frees a slot
  always_comb begin
    push  = accept && emit;
    pop   = (fifo_cnt_q != '0) && i_byte_ready;
    full  = (fifo_cnt_q == FifoFull);
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (i_start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: ;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en && !i_start) begin
      mem_q[wr_ptr_q] <= acc_sum[7:0];
    end
  end

  assign o_poly_we    = poly_we_q;
  assign o_poly_addr  = poly_addr_q;
  assign o_poly_data  = poly_data_q;
  assign o_byte_valid = (fifo_cnt_q != '0);
  assign o_byte_data  = mem_q[rd_ptr_q];
  assign o_overflow   = overflow_q;
  assign o_range_err  = range_err_q;

endmodule
